// File: rtl/dataram_arb_pkg.sv
// Shared definitions for the DataRAM arbiter and its round-robin picker.
//   arbState_t      : sequencer states (IDLE/WRITE/READ/RESP = 0..3)
//   PORT0 / PORT1   : requester IDs as carried on grant/pick
//   DEFAULT_TIMEOUT : READ cycles allowed before a read completes with error
package dataram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } arbState_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick.
//   req[1:0] in  : request per port (bit n = port n)
//   last     in  : port most recently served
//   pick     out : port to serve; on a tie the port other than last wins
module rr_arbiter2
  import dataram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick
);

  always_comb begin
    pick = last;
    case (req)
      2'b01:   pick = PORT0;
      2'b10:   pick = PORT1;
      2'b11:   pick = ~last;
      default: pick = last;
    endcase
  end

endmodule

// File: rtl/dataram_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-ported DataRAM.
//   clk, clr                  : clock, asynchronous active-high reset
//   pN_req/we/addr/wdata      : requester N transaction (held until ack)
//   pN_ack/err/rdata          : one-cycle completion, timeout flag, read data
//   ram_write_enable/read_enable/addr/read_addr/write_data : to DataRAM
//   ram_data_ready/read_data  : from DataRAM
//   busy                      : sequencer not in IDLE
//   grant                     : port currently or most recently served
module dataram_arbiter
  import dataram_arb_pkg::*;
#(
  parameter int unsigned width   = 16,
  parameter int unsigned length  = 8,
  parameter int unsigned timeout = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [length-1:0] p0_addr,
  input  logic [width-1:0]  p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [length-1:0] p1_addr,
  input  logic [width-1:0]  p1_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [width-1:0]  p0_rdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [width-1:0]  p1_rdata,
  output logic              ram_write_enable,
  output logic              ram_read_enable,
  output logic [length-1:0] ram_addr,
  output logic [length-1:0] ram_read_addr,
  output logic [width-1:0]  ram_write_data,
  input  logic              ram_data_ready,
  input  logic [width-1:0]  ram_read_data,
  output logic              busy,
  output logic              grant
);

  localparam logic [3:0] TIMEOUT_L = 4'(timeout);

  arbState_t         state;
  logic [3:0]        cnt;
  logic [3:0]        cntNext;
  logic              pick;
  logic              selWe;
  logic [length-1:0] selAddr;
  logic [width-1:0]  selWdata;

  rr_arbiter2 uPick (
    .req  ({p1_req, p0_req}),
    .last (grant),
    .pick (pick)
  );

  always_comb begin
    selWe    = (pick == PORT1) ? p1_we    : p0_we;
    selAddr  = (pick == PORT1) ? p1_addr  : p0_addr;
    selWdata = (pick == PORT1) ? p1_wdata : p0_wdata;
    cntNext  = cnt + 4'd1;
  end

  // ram_addr doubles as the address latch, so readAddr mirrors it directly.
  assign ram_read_addr = ram_addr;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state            <= IDLE;
      grant            <= PORT1;
      cnt              <= '0;
      busy             <= 1'b0;
      ram_write_enable <= 1'b0;
      ram_read_enable  <= 1'b0;
      ram_addr         <= '0;
      ram_write_data   <= '0;
      p0_ack           <= 1'b0;
      p1_ack           <= 1'b0;
      p0_err           <= 1'b0;
      p1_err           <= 1'b0;
      p0_rdata         <= '0;
      p1_rdata         <= '0;
    end else begin
      // ack/err are single-cycle: asserted on entry to RESP, cleared here after.
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      p0_err <= 1'b0;
      p1_err <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            grant          <= pick;
            ram_addr       <= selAddr;
            ram_write_data <= selWdata;
            cnt            <= '0;
            busy           <= 1'b1;
            if (selWe) begin
              state            <= WRITE;
              ram_write_enable <= 1'b1;
            end else begin
              state           <= READ;
              ram_read_enable <= 1'b1;
            end
          end
        end
        WRITE: begin
          ram_write_enable <= 1'b0;
          state            <= RESP;
          if (grant == PORT0) p0_ack <= 1'b1;
          else                p1_ack <= 1'b1;
        end
        READ: begin
          if (ram_data_ready) begin
            ram_read_enable <= 1'b0;
            state           <= RESP;
            if (grant == PORT0) begin
              p0_ack   <= 1'b1;
              p0_rdata <= ram_read_data;
            end else begin
              p1_ack   <= 1'b1;
              p1_rdata <= ram_read_data;
            end
          end else begin
            cnt <= cntNext;
            // cnt stops at timeout, so the 4-bit increment never wraps.
            if (cntNext >= TIMEOUT_L) begin
              ram_read_enable <= 1'b0;
              state           <= RESP;
              if (grant == PORT0) begin
                p0_ack <= 1'b1;
                p0_err <= 1'b1;
              end else begin
                p1_ack <= 1'b1;
                p1_err <= 1'b1;
              end
            end
          end
        end
        RESP: begin
          state          <= IDLE;
          busy           <= 1'b0;
          ram_addr       <= '0;
          ram_write_data <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dataram_arbiter.sv
module tb_dataram_arbiter;

  localparam int unsigned W  = 16;
  localparam int unsigned L  = 8;
  localparam int unsigned TO = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic         p0_req, p0_we, p1_req, p1_we;
  logic [L-1:0] p0_addr, p1_addr;
  logic [W-1:0] p0_wdata, p1_wdata;
  logic         p0_ack, p0_err, p1_ack, p1_err;
  logic [W-1:0] p0_rdata, p1_rdata;
  logic         ram_write_enable, ram_read_enable;
  logic [L-1:0] ram_addr, ram_read_addr;
  logic [W-1:0] ram_write_data;
  logic         ram_data_ready = 1'b0;
  logic [W-1:0] ram_read_data  = '0;
  logic         busy, grant;

  dataram_arbiter #(.width(W), .length(L), .timeout(TO)) dut (
    .clk(clk), .clr(clr),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
    .ram_addr(ram_addr), .ram_read_addr(ram_read_addr),
    .ram_write_data(ram_write_data), .ram_data_ready(ram_data_ready),
    .ram_read_data(ram_read_data), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned nVec = 0;
  int unsigned nMis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // DataRAM model: write commits and read data/ready settle on the falling edge.
  logic [W-1:0] mem [0:255];
  logic         stall = 1'b0;
  int unsigned  weCount = 0, reCount = 0;
  logic [L-1:0] weAddr = '0;
  logic [W-1:0] weData = '0;

  always @(negedge clk) begin
    if (ram_write_enable) mem[ram_addr] <= ram_write_data;
    if (ram_read_enable) ram_read_data <= mem[ram_read_addr];
    ram_data_ready <= ram_read_enable && !stall;
  end

  always @(negedge clk) begin
    if (ram_write_enable) begin
      weCount++;
      weAddr = ram_addr;
      weData = ram_write_data;
    end
    if (ram_read_enable) reCount++;
  end

  // Scoreboard
  typedef struct {
    logic        isRead;
    logic        err;
    logic [W-1:0] rdata;
    int unsigned cycle;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic handleAck(input bit port, input logic err, input logic [W-1:0] rdata);
    exp_t e;
    if ((port == 0 && q0.size() == 0) || (port == 1 && q1.size() == 0)) begin
      nVec++;
      nMis++;
      $display("FAIL p%0dUnexpectedAck: got ack expected none (cycle %0d)", port, cyc);
    end else begin
      if (port == 0) e = q0.pop_front();
      else           e = q1.pop_front();
      check($sformatf("p%0dAckCycle", port), cyc, e.cycle);
      check($sformatf("p%0dErr", port), {31'd0, err}, {31'd0, e.err});
      if (e.isRead) check($sformatf("p%0dRdata", port), {16'd0, rdata}, {16'd0, e.rdata});
    end
  endtask

  always @(negedge clk) begin
    check("enablesExclusive", {31'd0, ram_write_enable & ram_read_enable}, 32'd0);
    check("readAddrMirror", {24'd0, ram_read_addr}, {24'd0, ram_addr});
    if (p0_ack) handleAck(0, p0_err, p0_rdata);
    if (p1_ack) handleAck(1, p1_err, p1_rdata);
  end

  // Requester tasks
  task automatic issue(input bit port, input bit we, input logic [L-1:0] addr, input logic [W-1:0] wdata);
    if (port == 0) begin
      p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end else begin
      p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end
  endtask

  task automatic expectAck(input bit port, input bit isRead, input bit err,
                           input logic [W-1:0] rdata, input int unsigned cycle);
    exp_t e;
    e.isRead = isRead;
    e.err    = err;
    e.rdata  = rdata;
    e.cycle  = cycle;
    if (port == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  task automatic waitAck(input bit port);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      nVec++;
      nMis++;
      $display("FAIL p%0dAckWait: got no ack expected ack within 40 cycles", port);
    end
  endtask

  task automatic dropReq(input bit port);
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
  endtask

  task automatic runOp(input bit port, input bit we, input logic [L-1:0] addr,
                       input logic [W-1:0] wdata, input bit err,
                       input logic [W-1:0] rdata, input int unsigned lat);
    int unsigned c0;
    c0 = cyc;
    issue(port, we, addr, wdata);
    expectAck(port, !we, err, rdata, c0 + lat);
    waitAck(port);
    @(posedge clk); #1;
    dropReq(port);
  endtask

  task automatic pulseReset();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned c0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'hF0] = 16'hA5C3;
    mem[8'hF1] = 16'h3C5A;
    clr = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    repeat (2) @(posedge clk); #1;

    // Reset state
    check("rstGrant", {31'd0, grant}, 32'd1);
    check("rstBusy", {31'd0, busy}, 32'd0);
    check("rstEnables", {30'd0, ram_write_enable, ram_read_enable}, 32'd0);
    check("rstAcks", {28'd0, p0_ack, p1_ack, p0_err, p1_err}, 32'd0);
    check("rstAddr", {24'd0, ram_addr}, 32'd0);
    check("rstWdata", {16'd0, ram_write_data}, 32'd0);
    check("rstRdata", {p0_rdata, p1_rdata}, 32'd0);
    clr = 1'b0;

    // p0 write 0x05 <- 0x1234
    weCount = 0;
    c0 = cyc;
    issue(0, 1, 8'h05, 16'h1234);
    expectAck(0, 0, 0, '0, c0 + 2);
    @(posedge clk); #1;
    check("wrBusy", {31'd0, busy}, 32'd1);
    check("wrGrant", {31'd0, grant}, 32'd0);
    waitAck(0);
    @(posedge clk); #1;
    dropReq(0);
    check("wrEnableCycles", weCount, 32'd1);
    check("wrAddr", {24'd0, weAddr}, 32'h05);
    check("wrData", {16'd0, weData}, 32'h1234);
    check("idleAddrZero", {24'd0, ram_addr}, 32'd0);

    // p1 read 0x05
    reCount = 0;
    runOp(1, 0, 8'h05, '0, 0, 16'h1234, 2);
    check("rdEnableCycles", reCount, 32'd1);

    // Simultaneous requests from reset: p0 first, then strict alternation
    pulseReset();
    check("tieGrantReset", {31'd0, grant}, 32'd1);
    for (int r = 0; r < 3; r++) begin
      fork
        runOp(0, 1, 8'(16 + 2 * r), 16'(16'h1111 * (r + 1)), 0, '0, 2);
        runOp(1, 1, 8'(17 + 2 * r), 16'(16'h2222 * (r + 1)), 0, '0, 5);
        begin
          @(posedge clk); #1;
          check("tieGrantFirst", {31'd0, grant}, 32'd0);
          repeat (3) @(posedge clk);
          #1;
          check("tieGrantSecond", {31'd0, grant}, 32'd1);
        end
      join
    end

    // Timeout: prime p0_rdata, then stall the RAM
    runOp(0, 0, 8'h05, '0, 0, 16'h1234, 2);
    stall = 1'b1;
    reCount = 0;
    runOp(0, 0, 8'hF0, '0, 1, 16'h1234, 1 + TO);
    check("toReadCycles", reCount, TO);
    stall = 1'b0;

    // Reset during READ, pending request re-served afterwards
    stall = 1'b1;
    issue(1, 0, 8'hF1, '0);
    @(posedge clk); #1;
    check("preClrReadEn", {31'd0, ram_read_enable}, 32'd1);
    #2;
    clr = 1'b1;
    #1;
    check("clrEnables", {30'd0, ram_write_enable, ram_read_enable}, 32'd0);
    check("clrAcks", {30'd0, p0_ack, p1_ack}, 32'd0);
    check("clrBusy", {31'd0, busy}, 32'd0);
    check("clrAddr", {24'd0, ram_addr}, 32'd0);
    check("clrP0Rdata", {16'd0, p0_rdata}, 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    stall = 1'b0;
    c0 = cyc;
    expectAck(1, 1, 0, 16'h3C5A, c0 + 2);
    waitAck(1);
    @(posedge clk); #1;
    dropReq(1);

    // Back-to-back p0 reads 0xF0, 0xF1
    reCount = 0;
    c0 = cyc;
    issue(0, 0, 8'hF0, '0);
    expectAck(0, 1, 0, 16'hA5C3, c0 + 2);
    waitAck(0);
    #1;
    check("b2bReadyLowResp1", {31'd0, ram_data_ready}, 32'd0);
    @(posedge clk); #1;
    issue(0, 0, 8'hF1, '0);
    expectAck(0, 1, 0, 16'h3C5A, c0 + 5);
    waitAck(0);
    #1;
    check("b2bReadyLowResp2", {31'd0, ram_data_ready}, 32'd0);
    @(posedge clk); #1;
    dropReq(0);
    check("b2bReadCycles", reCount, 32'd2);

    repeat (3) @(posedge clk);
    #1;
    check("q0Drained", q0.size(), 32'd0);
    check("q1Drained", q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
